// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU)
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_data1,
    input  logic [XLEN-1:0] i_data2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t          r_state, w_next;
    logic [4:0]      r_cnt;
    logic [1:0]      r_op;
    logic            r_neg_q, r_neg_r;
    logic [XLEN-1:0] r_div, r_quo, r_rem;
    logic            r_busy, r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed, w_div_zero, w_ovf, w_fast, w_accept;
    logic [XLEN-1:0] w_abs1, w_abs2, w_fast_val;
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_q_fix, w_r_fix, w_fix_val;
    logic            w_load;
    logic [XLEN-1:0] w_load_val;

    assign w_signed   = ~i_div_op[0];
    assign w_div_zero = (i_data2 == '0);
    assign w_ovf      = w_signed && (i_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_data2 == '1);
    assign w_fast     = w_div_zero || w_ovf;
    assign w_accept   = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_abs1     = (w_signed && i_data1[XLEN-1]) ? -i_data1 : i_data1;
    assign w_abs2     = (w_signed && i_data2[XLEN-1]) ? -i_data2 : i_data2;

    // Zero divisor wins over overflow; both resolve without entering CALC
    assign w_fast_val = w_div_zero ? (i_div_op[1] ? i_data1 : '1)
                                   : (i_div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One restoring step: remainder stays below the divisor, so the difference fits XLEN bits
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift - {1'b0, r_div};

    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_fix_val = r_op[1] ? w_r_fix : w_q_fix;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_fast) w_next = S_CALC;
            S_CALC:  if (i_flush) w_next = S_IDLE;
                     else if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_accept && w_fast) begin
            w_load     = 1'b1;
            w_load_val = w_fast_val;
        end else if (r_state == S_FIX && !i_flush) begin
            w_load     = 1'b1;
            w_load_val = w_fix_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= w_load;
            if (w_load) r_result <= w_load_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
        end else if (w_accept && !w_fast) begin
            r_cnt   <= '0;
            r_op    <= i_div_op;
            r_neg_q <= w_signed && (i_data1[XLEN-1] ^ i_data2[XLEN-1]);
            r_neg_r <= w_signed && i_data1[XLEN-1];
            r_div   <= w_abs2;
            r_quo   <= w_abs1;
            r_rem   <= '0;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_flush;
    logic [1:0]  i_div_op;
    logic [31:0] i_data1, i_data2;
    logic        o_busy, o_done;
    logic [31:0] o_result;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_sequencer #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_div_op(i_div_op),
        .i_data1(i_data1), .i_data2(i_data2), .i_flush(i_flush),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start  = 1'b1;
        i_div_op = op;
        i_data1  = a;
        i_data2  = b;
    endtask

    // Called at the negedge where START is presented; returns at the negedge of the DONE cycle
    task automatic wait_done(output int lat, output int busy_cyc);
        @(negedge i_clk);
        i_start  = 1'b0;
        i_div_op = ~i_div_op;
        i_data1  = $urandom;
        i_data2  = $urandom;
        lat      = 1;
        busy_cyc = 0;
        while (!o_done && lat < 80) begin
            if (o_busy) busy_cyc++;
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        start_op(op, a, b);
        wait_done(lat, bc);
        check({tag, "_result"}, o_result, exp);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bc, (exp_lat == 1) ? 0 : 33);
        @(negedge i_clk);
        check({tag, "_done_one_cycle"}, {31'b0, o_done}, 32'd0);
    endtask

    initial begin
        int lat, bc, saw_done;
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_div_op = 2'b00; i_data1 = '0; i_data2 = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_result", o_result, 32'd0);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);

        // Flush mid-CALC: no DONE, RESULT keeps 5
        start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_busy_low", {31'b0, o_busy}, 32'd0);
        saw_done = 0;
        repeat (40) begin
            if (o_done) saw_done = 1;
            @(negedge i_clk);
        end
        check("flush_no_done", saw_done, 0);
        check("flush_result_kept", o_result, 32'd5);

        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

        // Reset mid-CALC clears RESULT and BUSY
        start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_mid_busy", {31'b0, o_busy}, 32'd0);
        check("rst_mid_result", o_result, 32'd0);

        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_no_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // START while busy is ignored
        start_op(OP_DIVU, 32'd100, 32'd7);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        start_op(OP_DIVU, 32'd9, 32'd3);
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 6;
        while (!o_done && lat < 80) begin
            @(negedge i_clk);
            lat++;
        end
        check("ignore_start_result", o_result, 32'd14);
        check("ignore_start_latency", lat, 34);

        // START in the DONE cycle is accepted
        start_op(OP_DIVU, 32'd9, 32'd3);
        wait_done(lat, bc);
        check("b2b_result", o_result, 32'd3);
        check("b2b_latency", lat, 34);
        check("b2b_busy_cycles", bc, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU) in the EX stage. The combinational ALU keeps the single-cycle operations; this block owns the divide path. It runs a 32-step restoring division over 34 cycles and asserts BUSY so the hazard unit holds the pipeline. It resolves divide-by-zero and signed overflow in one cycle, and a pipeline flush can abort it.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only when state is IDLE
- DIV_OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- DATA1  input  32  dividend (rs1)
- DATA2  input  32  divisor (rs2)
- FLUSH  input  1  synchronous abort of the in-flight operation
- BUSY  output  1  high while state ≠ IDLE; the hazard unit stalls IF/ID/EX on it
- DONE  output  1  one-cycle pulse, RESULT valid
- RESULT  output  32  quotient or remainder; holds until next DONE

## Operation
- States:
  - IDLE: BUSY=0.
  - CALC: 32 steps, 5-bit step counter.
  - FIX: sign correction and result load.
- Priority per edge: RESET > FLUSH > START.
- Reset values: state IDLE, BUSY 0, DONE 0, RESULT 0, counter 0, internal registers 0.
- IDLE with START=1:
  - DATA1, DATA2 and DIV_OP are captured. Later input changes are ignored.
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → DATA1. Load RESULT, pulse DONE, stay IDLE.
  - DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: DIV → 0x80000000, REM → 0. Load RESULT, pulse DONE, stay IDLE.
  - All other cases go to CALC with counter=0.
- Signed ops divide magnitudes |DATA1| and |DATA2|. |0x80000000| is treated as unsigned 0x80000000.
- CALC step, one per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the result is non-negative, keep it and set quo[0]=1.
  - After step 32 (counter = 31), go to FIX.
- FIX (one edge):
  - Negate the quotient if the signed op has operands of differing sign.
  - The remainder takes the sign of the dividend.
  - Select the quotient or remainder per DIV_OP, load RESULT, pulse DONE, go to IDLE.
- START while BUSY=1 is ignored, not queued.
- FLUSH while BUSY: go to IDLE next edge, no DONE, RESULT unchanged. FLUSH in IDLE cancels a same-cycle START.

## Timing
- The edge where START is sampled in IDLE is edge 0.
- Fast path (zero divisor or overflow): DONE=1 and RESULT valid in the cycle after edge 0. BUSY never rises. Latency 1.
- Normal path:
  - BUSY rises after edge 0.
  - CALC spans edges 1–32; FIX happens at edge 33.
  - DONE=1 and BUSY=0 in the cycle after edge 33. Latency 34 cycles.
- DONE is high for exactly one cycle. A new START in the DONE cycle is accepted, so back-to-back throughput is 34 cycles.
- RESET or FLUSH mid-CALC: BUSY=0 in the very next cycle. RESET also clears RESULT to 0.
- No combinational path from inputs to outputs. BUSY, DONE and RESULT are registered.

## Test plan
- DIVU 100/7 → 34 cycles after START, DONE pulse, RESULT=14; repeat with REMU → RESULT=2. BUSY high for exactly 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → RESULT 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). REM 7 / 0xFFFFFFFE (−2) → 1.
- Divisor 0:
  - DIVU 5/0 → RESULT 0xFFFFFFFF with DONE the cycle after START, BUSY stays 0.
  - REM 5/0 → RESULT 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in 1 cycle; REM → 0.
- DIVU 0xFFFFFFFF/1:
  - Assert FLUSH 10 cycles after START → BUSY low next cycle, no DONE, RESULT keeps its prior value.
  - Restart DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
  - RESET mid-CALC → RESULT 0, BUSY 0.
- Start DIVU 100/7, pulse START with DIVU 9/3 at cycle 5 → ignored, RESULT=14.
  - START DIVU 9/3 in the DONE cycle → accepted, RESULT=3 after 34 more cycles.
